// File: rtl/debounced_edge_pio.sv
// Avalon-MM input PIO: two-flop synchroniser, counter debounce, selectable edge
// capture with write-1-to-clear, and a masked registered interrupt.
module debounced_edge_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RISE_EN_INIT    = '0,
    parameter logic [WIDTH-1:0] FALL_EN_INIT    = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // A one-cycle filter still needs a 1-bit counter to keep the arrays legal.
    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] db_dly_q, db_dly_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] rd_sel;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    always_comb begin
        s1_d     = in_port;
        s2_d     = s1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        if (wr_en) begin
            case (address)
                3'd2:    mask_d    = wdata;
                3'd3:    clr       = wdata;
                3'd4:    rise_en_d = wdata;
                3'd5:    fall_en_d = wdata;
                default: ;
            endcase
        end
        evt   = (db_q & ~db_dly_q & rise_en_q) | (~db_q & db_dly_q & fall_en_q);
        // New events are OR-ed in after the clear so a coincident edge survives.
        cap_d = (cap_q & ~clr) | evt;
        irq_d = |(cap_d & mask_q);
    end

    always_comb begin
        rd_sel = '0;
        case (address)
            3'd0:    rd_sel = db_q;
            3'd1:    rd_sel = s2_q;
            3'd2:    rd_sel = mask_q;
            3'd3:    rd_sel = cap_q;
            3'd4:    rd_sel = rise_en_q;
            3'd5:    rd_sel = fall_en_q;
            default: rd_sel = '0;
        endcase
        readdata_d = 32'(rd_sel);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= IDLE_LEVEL;
            s2_q       <= IDLE_LEVEL;
            db_q       <= IDLE_LEVEL;
            db_dly_q   <= IDLE_LEVEL;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_en_q  <= RISE_EN_INIT;
            fall_en_q  <= FALL_EN_INIT;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            db_q       <= db_d;
            db_dly_q   <= db_dly_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_debounced_edge_pio.sv
// Directed bench for debounced_edge_pio (WIDTH=4, DEBOUNCE_CYCLES=16) with a
// read-expectation queue and immediate assertions at every comparison.
module tb_debounced_edge_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    debounced_edge_pio #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        address = a;
        @(posedge clk);
        @(negedge clk);
        check(tag, readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (100) @(negedge clk);

        // Idle after reset
        rd(3'd0, 32'hF, "idle_data");
        rd(3'd1, 32'hF, "idle_raw");
        rd(3'd3, 32'h0, "idle_cap");
        rd(3'd2, 32'h0, "idle_mask");
        rd(3'd4, 32'h0, "idle_rise_en");
        rd(3'd5, 32'hF, "idle_fall_en");
        check("idle_irq", {31'b0, irq}, 32'h0);

        // Single clean fall on bit 0
        wr(3'd2, 32'h1);
        in_port = 4'hE;
        repeat (17) @(posedge clk);
        @(negedge clk);
        rd(3'd0, 32'hF, "fall_data_edge17");
        check("fall_irq_edge18", {31'b0, irq}, 32'h0);
        rd(3'd0, 32'hE, "fall_data_edge18");
        check("fall_irq_edge19", {31'b0, irq}, 32'h1);
        rd(3'd3, 32'h1, "fall_cap");

        // Bouncing bit 1: 10 low, 3 high, then stable low
        wr(3'd2, 32'h2);
        wr(3'd3, 32'hF);
        in_port = 4'hC;
        repeat (10) @(negedge clk);
        in_port = 4'hE;
        repeat (3) @(negedge clk);
        check("bounce_irq_quiet", {31'b0, irq}, 32'h0);
        in_port = 4'hC;
        repeat (18) @(posedge clk);
        @(negedge clk);
        check("bounce_irq_edge18", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("bounce_irq_edge19", {31'b0, irq}, 32'h1);
        rd(3'd0, 32'hC, "bounce_data");
        rd(3'd3, 32'h2, "bounce_cap_single");

        // Rise-only on bit 2
        wr(3'd4, 32'h4);
        wr(3'd5, 32'h0);
        wr(3'd3, 32'hF);
        in_port = 4'h8;
        repeat (30) @(negedge clk);
        rd(3'd3, 32'h0, "rise_only_press");
        in_port = 4'hC;
        repeat (30) @(negedge clk);
        rd(3'd3, 32'h4, "rise_only_release");
        in_port = 4'h4;
        repeat (30) @(negedge clk);
        in_port = 4'hC;
        repeat (30) @(negedge clk);
        rd(3'd3, 32'h4, "bit3_disabled");
        rd(3'd0, 32'hC, "rise_data");

        // Write-1-to-clear and set-wins collision
        wr(3'd4, 32'h3);
        wr(3'd3, 32'hF);
        in_port = 4'hF;
        repeat (30) @(negedge clk);
        rd(3'd3, 32'h3, "w1c_setup");
        check("w1c_irq", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h2, "w1c_partial");
        wr(3'd5, 32'h1);
        in_port = 4'hE;
        repeat (18) @(posedge clk);
        @(negedge clk);
        wr(3'd3, 32'h1);
        rd(3'd3, 32'h3, "set_wins");

        // Unmapped addresses, read-only writes, mask gating
        rd(3'd6, 32'h0, "addr6");
        rd(3'd7, 32'h0, "addr7");
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6, 32'h0, "addr6_after_wr");
        wr(3'd0, 32'h0);
        rd(3'd0, 32'hE, "data_ro");
        wr(3'd2, 32'hFFFF_FFFF);
        rd(3'd2, 32'hF, "mask_upper_zero");
        wr(3'd2, 32'h0);
        check("mask_irq_lag", {31'b0, irq}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("mask_zero_irq", {31'b0, irq}, 32'h0);
        rd(3'd3, 32'h3, "cap_pending");

        // Reset in the middle of a debounce count
        wr(3'd2, 32'h2);
        in_port = 4'hF;
        repeat (6) @(negedge clk);
        rd(3'd5, 32'h1, "pre_reset_read");
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        rd(3'd3, 32'h0, "post_reset_cap");
        rd(3'd2, 32'h0, "post_reset_mask");
        rd(3'd4, 32'h0, "post_reset_rise_en");
        rd(3'd5, 32'hF, "post_reset_fall_en");
        rd(3'd0, 32'hF, "post_reset_data");
        check("post_reset_irq", {31'b0, irq}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
